mul_sequencer: RTL and testbench
================================

# mul_sequencer

Multi-cycle shift-add sequencer for the integer multiply operation of the execute stage. It watches the decoded ALU control code and, when it sees the multiply code, captures both operands and stalls the pipeline while it iterates. It then returns the low DATA_W bits of the product with a one-cycle valid pulse. All other ALU codes pass through untouched: the combinational ALU handles them and this block stays idle.

## Interface
- DATA_W, 32, operand/result width (≥2).
- MUL_CODE, 4'd8, ALU control value that selects multiply.
- clk  input  1  single clock; all state changes on its rising edge.
- arst_n  input  1  reset, asynchronous and active-low.
- issue  input  1  an instruction in EX presents alu_ctrl/op_a/op_b this cycle.
- alu_ctrl  input  4  ALU control code from the ALU control decoder.
- op_a  input  DATA_W  multiplicand.
- op_b  input  DATA_W  multiplier.
- flush  input  1  synchronous abort (branch/exception squash of EX).
- stall  output  1  hold PC, IF/ID and ID/EX; combinational from state and inputs.
- busy  output  1  registered; high in BUSY state.
- result_valid  output  1  registered; one-cycle pulse when result is final.
- result  output  DATA_W  product[DATA_W-1:0]; holds last value until the next completion.

## Operation
- States: IDLE, BUSY, DONE. Registers: acc[DATA_W], mcand[DATA_W], mplier[DATA_W], cnt[$clog2(DATA_W+1)].
- accept = issue && alu_ctrl==MUL_CODE && !flush, evaluated in IDLE or DONE only.
- IDLE/DONE with accept: acc←0, mcand←op_a, mplier←op_b, cnt←DATA_W, go to BUSY.
- IDLE/DONE without accept: go to (or stay in) IDLE.
- BUSY step: if mplier[0], acc←acc+mcand (mod 2^DATA_W). Then mcand←mcand<<1, mplier←mplier>>1, cnt←cnt−1. When cnt==1 on this step, go to DONE.
- DONE: result_valid=1, result←acc (result registered on the BUSY→DONE edge).
- Arithmetic is unsigned shift-add truncated to DATA_W. The low half is identical for signed operands, so no sign handling is required.
- In BUSY, issue/alu_ctrl/op_a/op_b are ignored. The pipeline is frozen, so the same instruction is still presented and must not re-trigger.
- flush in BUSY: go to IDLE next edge, no result_valid, result unchanged. flush beats issue in the same cycle.
- Non-multiply codes (e.g. 4'd2 ADD, 4'd9 VHSUM) never assert stall or change state.
- stall = (state∈{IDLE,DONE} && accept) || (state==BUSY && !flush).
- Reset (async, any state): state=IDLE, stall=0, busy=0, result_valid=0, result=0, acc/mcand/mplier/cnt=0.

## Timing
- Accept sampled at cycle T. stall is high in cycles T..T+DATA_W (DATA_W+1 cycles). busy is high T+1..T+DATA_W. result_valid and result are valid at T+DATA_W+1, with stall low in that cycle.
- Total latency is DATA_W+1 cycles from issue to result_valid, fixed and independent of operand values.
- Back-to-back: accept in DONE cycle T' starts a new operation. result_valid for the previous op still pulses in T', and stall is high in T' for the new op.
- Reset deasserted mid-operation: the operation is lost. The block starts in IDLE and the first accepted issue follows normal timing.

## Test plan
- DATA_W=32, issue MUL op_a=7, op_b=6 at T → stall high T..T+32, busy T+1..T+32, result_valid=1 with result=42 at T+33 only.
- op_a=op_b=32'hFFFFFFFF → result=32'h00000001. op_a=0, op_b=32'h12345678 → result=0, same 33-cycle latency.
- issue with alu_ctrl=4'd2 and with 4'd9 → stall, busy and result_valid stay 0 and result is unchanged for 40 cycles.
- MUL 3×5 accepted, flush at T+10 → busy low at T+11, no result_valid. A following MUL 4×4 yields 16 after 33 cycles.
- MUL 3×5, then a new MUL 9×9 issued in the DONE cycle → result_valid=15 at T+33, second result_valid=81 at T+66, stall continuous T+33..T+65.
- arst_n pulsed low at T+5 (mid-cycle, asynchronous) → all outputs 0 immediately. After release, MUL 2×3 → 6 with normal latency.

Source files
------------

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//
// Multi-cycle shift-add multiplier for the execute stage. When the decoded ALU
// control code selects multiply, the block captures both operands, stalls the
// pipeline for DATA_W iterations and then returns the low DATA_W bits of the
// product together with a one-cycle valid pulse. All other ALU codes are left
// to the combinational ALU, and this block stays idle for them.
//
// Parameters:
//   DATA_W    operand/result width (>= 2)
//   MUL_CODE  ALU control value that selects multiply
//
// Ports:
//   clk           in   rising-edge clock
//   arst_n        in   asynchronous active-low reset
//   issue         in   an instruction in EX presents alu_ctrl/op_a/op_b
//   alu_ctrl      in   4-bit ALU control code
//   op_a          in   multiplicand
//   op_b          in   multiplier
//   flush         in   synchronous abort of the instruction in EX
//   stall         out  hold PC, IF/ID and ID/EX (combinational)
//   busy          out  high while iterating (decoded from the state register)
//   result_valid  out  one-cycle pulse when result is final
//   result        out  product[DATA_W-1:0]; held until the next completion
// -----------------------------------------------------------------------------
module mul_sequencer #(
  parameter int          DATA_W   = 32,
  parameter logic [3:0]  MUL_CODE = 4'd8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              issue,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              stall,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q,  state_d;
  logic [DATA_W-1:0]   acc_q,    acc_d;
  logic [DATA_W-1:0]   mcand_q,  mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic accept;
  logic stall_c;

  // A new multiply may only start from IDLE or DONE; a flush in the same
  // cycle squashes the instruction, so it must never be accepted.
  assign accept = issue && (alu_ctrl == MUL_CODE) && !flush;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    stall_c  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d  = S_BUSY;
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = CNT_W'(DATA_W);
          stall_c  = 1'b1;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_BUSY: begin
        if (flush) begin
          // Aborted: drop back to IDLE without touching the visible result.
          state_d = S_IDLE;
        end else begin
          stall_c  = 1'b1;
          acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = S_DONE;
            // The final step's partial product must be included, so the
            // result register takes the updated accumulator, not acc_q.
            result_d = acc_d;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // While reset is asserted the pipeline must not be held, even if a
  // multiply is being presented.
  assign stall        = arst_n & stall_c;
  assign busy         = (state_q == S_BUSY);
  assign result_valid = (state_q == S_DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
//
// Directed bench for mul_sequencer (DATA_W=32, MUL_CODE=8). Each cycle starts
// 1 time unit after the rising edge: inputs are driven there, and outputs are
// compared 1 unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_mul_sequencer;

  localparam int         DATA_W   = 32;
  localparam logic [3:0] MUL_CODE = 4'd8;

  logic              clk;
  logic              arst_n;
  logic              issue;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              flush;
  logic              stall;
  logic              busy;
  logic              result_valid;
  logic [DATA_W-1:0] result;

  int checks   = 0;
  int failures = 0;

  mul_sequencer #(
    .DATA_W   (DATA_W),
    .MUL_CODE (MUL_CODE)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .issue        (issue),
    .alu_ctrl     (alu_ctrl),
    .op_a         (op_a),
    .op_b         (op_b),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all four outputs at once.
  task automatic check_out(input string tag, input logic s, input logic b,
                           input logic v, input logic [DATA_W-1:0] r);
    check({tag, ".stall"},        DATA_W'(stall),        DATA_W'(s));
    check({tag, ".busy"},         DATA_W'(busy),         DATA_W'(b));
    check({tag, ".result_valid"}, DATA_W'(result_valid), DATA_W'(v));
    check({tag, ".result"},       result,                r);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a multiply in the current cycle T (block in IDLE or DONE) and
  // runs through T+32 with the instruction still presented, as a frozen
  // pipeline would. Returns positioned at T+33 (the DONE cycle) with the
  // multiply still on the inputs; the caller decides what to drive there.
  task automatic mul_body(input string tag, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b);
    issue    = 1'b1;
    alu_ctrl = MUL_CODE;
    op_a     = a;
    op_b     = b;
    flush    = 1'b0;
    #1;
    check({tag, ".T.stall"}, DATA_W'(stall), DATA_W'(1'b1));
    check({tag, ".T.busy"},  DATA_W'(busy),  DATA_W'(1'b0));
    for (int i = 1; i <= DATA_W; i++) begin
      next_cycle();
      #1;
      check({tag, ".run.stall"}, DATA_W'(stall),        DATA_W'(1'b1));
      check({tag, ".run.busy"},  DATA_W'(busy),         DATA_W'(1'b1));
      check({tag, ".run.valid"}, DATA_W'(result_valid), DATA_W'(1'b0));
    end
    next_cycle();
  endtask

  // Completes a single multiply: DONE cycle with nothing new issued, then
  // one IDLE cycle to confirm the pulse is single and the result holds.
  task automatic mul_single(input string tag, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b,
                            input logic [DATA_W-1:0] exp);
    mul_body(tag, a, b);
    issue = 1'b0;
    #1;
    check_out({tag, ".done"}, 1'b0, 1'b0, 1'b1, exp);
    next_cycle();
    #1;
    check_out({tag, ".after"}, 1'b0, 1'b0, 1'b0, exp);
  endtask

  initial begin
    arst_n   = 1'b0;
    issue    = 1'b0;
    alu_ctrl = 4'd0;
    op_a     = '0;
    op_b     = '0;
    flush    = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 1'b0, 1'b0, 32'd0);
    arst_n = 1'b1;
    next_cycle();
    #1;
    check_out("idle", 1'b0, 1'b0, 1'b0, 32'd0);

    // Basic products, fixed 33-cycle latency regardless of operands.
    next_cycle();
    mul_single("m7x6", 32'd7, 32'd6, 32'd42);
    next_cycle();
    mul_single("m0xN", 32'd0, 32'h1234_5678, 32'd0);
    next_cycle();
    mul_single("mFFxFF", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

    // Non-multiply codes must leave the block idle and the result alone.
    next_cycle();
    issue    = 1'b1;
    alu_ctrl = 4'd2;
    op_a     = 32'd11;
    op_b     = 32'd13;
    for (int i = 0; i < 20; i++) begin
      #1;
      check_out("add", 1'b0, 1'b0, 1'b0, 32'h0000_0001);
      next_cycle();
    end
    alu_ctrl = 4'd9;
    for (int i = 0; i < 20; i++) begin
      #1;
      check_out("vhsum", 1'b0, 1'b0, 1'b0, 32'h0000_0001);
      next_cycle();
    end
    issue = 1'b0;

    // Flush at T+10 aborts 3x5: no pulse, result unchanged.
    next_cycle();
    issue    = 1'b1;
    alu_ctrl = MUL_CODE;
    op_a     = 32'd3;
    op_b     = 32'd5;
    #1;
    check("flush.T.stall", DATA_W'(stall), DATA_W'(1'b1));
    for (int i = 1; i <= 9; i++) begin
      next_cycle();
      #1;
      check("flush.run.busy", DATA_W'(busy), DATA_W'(1'b1));
    end
    next_cycle();                 // T+10: flush beats the still-presented MUL
    flush = 1'b1;
    #1;
    check_out("flush.T10", 1'b0, 1'b1, 1'b0, 32'h0000_0001);
    next_cycle();                 // T+11
    flush = 1'b0;
    issue = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      check_out("flush.idle", 1'b0, 1'b0, 1'b0, 32'h0000_0001);
      next_cycle();
    end
    mul_single("m4x4", 32'd4, 32'd4, 32'd16);

    // Back-to-back: 9x9 issued in the DONE cycle of 3x5.
    next_cycle();
    mul_body("b2b1", 32'd3, 32'd5);
    op_a = 32'd9;                 // T+33: new MUL presented in DONE
    op_b = 32'd9;
    #1;
    check_out("b2b1.done", 1'b1, 1'b0, 1'b1, 32'd15);
    for (int i = 1; i <= DATA_W; i++) begin
      next_cycle();
      #1;
      check_out("b2b2.run", 1'b1, 1'b1, 1'b0, 32'd15);
    end
    next_cycle();                 // T+66
    issue = 1'b0;
    #1;
    check_out("b2b2.done", 1'b0, 1'b0, 1'b1, 32'd81);
    next_cycle();
    #1;
    check_out("b2b2.after", 1'b0, 1'b0, 1'b0, 32'd81);

    // Asynchronous reset mid-operation, with the MUL still presented.
    next_cycle();
    issue    = 1'b1;
    alu_ctrl = MUL_CODE;
    op_a     = 32'd2;
    op_b     = 32'd3;
    for (int i = 1; i <= 5; i++) next_cycle();
    #3;
    arst_n = 1'b0;
    #1;
    check_out("arst", 1'b0, 1'b0, 1'b0, 32'd0);
    next_cycle();
    #1;
    check_out("arst.hold", 1'b0, 1'b0, 1'b0, 32'd0);
    issue  = 1'b0;
    arst_n = 1'b1;
    next_cycle();
    #1;
    check_out("arst.idle", 1'b0, 1'b0, 1'b0, 32'd0);
    next_cycle();
    mul_single("m2x3", 32'd2, 32'd3, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
